// File: rtl/vending_panel_arbiter.sv
// vending_panel_arbiter: round-robin sharing of one vending core among four panels,
// with registered result reporting and a sticky balance-mismatch flag.
module vending_panel_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [7:0] panel_item,
  input  logic [7:0] panel_coin50,
  input  logic [7:0] panel_coin10,
  input  logic [7:0] panel_coin5,
  input  logic [7:0] panel_coin1,
  output logic [3:0] gnt,
  output logic [3:0] done,
  output logic [1:0] res_item,
  output logic [2:0] res_coin50,
  output logic [2:0] res_coin10,
  output logic [2:0] res_coin5,
  output logic [2:0] res_coin1,
  output logic       res_timeout,
  output logic       acct_err,
  output logic [1:0] core_itemTypeIn,
  output logic [1:0] core_coinInNTD_50,
  output logic [1:0] core_coinInNTD_10,
  output logic [1:0] core_coinInNTD_5,
  output logic [1:0] core_coinInNTD_1,
  input  logic [1:0] core_serviceTypeOut,
  input  logic [1:0] core_itemTypeOut,
  input  logic [2:0] core_coinOutNTD_50,
  input  logic [2:0] core_coinOutNTD_10,
  input  logic [2:0] core_coinOutNTD_5,
  input  logic [2:0] core_coinOutNTD_1
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, REFUND, REPORT} state_t;
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, sel_q, sel_d, item_q, item_d;
  logic [1:0] c50_q, c50_d, c10_q, c10_d, c5_q, c5_d, c1_q, c1_d;
  logic [7:0] inv_q, inv_d, cnt_q, cnt_d;
  logic [3:0] gnt_q, gnt_d, done_q, done_d;
  logic [1:0] r_item_q, r_item_d;
  logic [2:0] r50_q, r50_d, r10_q, r10_d, r5_q, r5_d, r1_q, r1_d;
  logic       r_to_q, r_to_d, err_q, err_d;
  logic [1:0] ci_q, ci_d, ci50_q, ci50_d, ci10_q, ci10_d, ci5_q, ci5_d, ci1_q, ci1_d;
  logic [1:0] pick, idx, p_item, p50, p10, p5, p1;
  logic       hit;
  logic [9:0] out_val;
  always_comb begin
    hit = 1'b0;
    pick = ptr_q;
    idx = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (req[idx]) begin
        hit = 1'b1;
        pick = idx;
      end
    end
  end
  assign p_item = panel_item[{pick, 1'b0} +: 2];
  assign p50 = panel_coin50[{pick, 1'b0} +: 2];
  assign p10 = panel_coin10[{pick, 1'b0} +: 2];
  assign p5 = panel_coin5[{pick, 1'b0} +: 2];
  assign p1 = panel_coin1[{pick, 1'b0} +: 2];
  // change returned plus the price of whatever item was dispensed
  assign out_val = 10'(r50_q * 50 + r10_q * 10 + r5_q * 5 + r1_q) +
                   (r_item_q == 2'd1 ? 10'd8 : r_item_q == 2'd2 ? 10'd15 : r_item_q == 2'd3 ? 10'd22 : 10'd0);
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    sel_d = sel_q;
    item_d = item_q;
    c50_d = c50_q;
    c10_d = c10_q;
    c5_d = c5_q;
    c1_d = c1_q;
    inv_d = inv_q;
    cnt_d = cnt_q;
    gnt_d = '0;
    done_d = '0;
    r_item_d = r_item_q;
    r50_d = r50_q;
    r10_d = r10_q;
    r5_d = r5_q;
    r1_d = r1_q;
    r_to_d = r_to_q;
    err_d = err_q;
    ci_d = '0;
    ci50_d = '0;
    ci10_d = '0;
    ci5_d = '0;
    ci1_d = '0;
    case (state_q)
      IDLE: if (hit && core_serviceTypeOut == 2'b01) begin
        gnt_d = 4'b0001 << pick;
        sel_d = pick;
        item_d = p_item;
        c50_d = p50;
        c10_d = p10;
        c5_d = p5;
        c1_d = p1;
        inv_d = 8'(p50 * 50 + p10 * 10 + p5 * 5 + p1);
        state_d = p_item == 2'b00 ? REFUND : ISSUE;
        if (p_item != 2'b00) begin
          ci_d = p_item;
          ci50_d = p50;
          ci10_d = p10;
          ci5_d = p5;
          ci1_d = p1;
        end
      end
      ISSUE: begin
        cnt_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (core_serviceTypeOut == 2'b00) begin
          r_item_d = core_itemTypeOut;
          r50_d = core_coinOutNTD_50;
          r10_d = core_coinOutNTD_10;
          r5_d = core_coinOutNTD_5;
          r1_d = core_coinOutNTD_1;
          r_to_d = 1'b0;
          state_d = REPORT;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          r_item_d = '0;
          r50_d = '0;
          r10_d = '0;
          r5_d = '0;
          r1_d = '0;
          r_to_d = 1'b1;
          state_d = REPORT;
        end
      end
      REFUND: begin
        r_item_d = '0;
        r50_d = {1'b0, c50_q};
        r10_d = {1'b0, c10_q};
        r5_d = {1'b0, c5_q};
        r1_d = {1'b0, c1_q};
        r_to_d = 1'b0;
        state_d = REPORT;
      end
      REPORT: begin
        done_d = 4'b0001 << sel_q;
        ptr_d = sel_q + 2'd1;
        err_d = err_q | (!r_to_q && {2'b00, inv_q} != out_val);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      sel_q <= '0;
      item_q <= '0;
      c50_q <= '0;
      c10_q <= '0;
      c5_q <= '0;
      c1_q <= '0;
      inv_q <= '0;
      cnt_q <= '0;
      gnt_q <= '0;
      done_q <= '0;
      r_item_q <= '0;
      r50_q <= '0;
      r10_q <= '0;
      r5_q <= '0;
      r1_q <= '0;
      r_to_q <= 1'b0;
      err_q <= 1'b0;
      ci_q <= '0;
      ci50_q <= '0;
      ci10_q <= '0;
      ci5_q <= '0;
      ci1_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      sel_q <= sel_d;
      item_q <= item_d;
      c50_q <= c50_d;
      c10_q <= c10_d;
      c5_q <= c5_d;
      c1_q <= c1_d;
      inv_q <= inv_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
      r_item_q <= r_item_d;
      r50_q <= r50_d;
      r10_q <= r10_d;
      r5_q <= r5_d;
      r1_q <= r1_d;
      r_to_q <= r_to_d;
      err_q <= err_d;
      ci_q <= ci_d;
      ci50_q <= ci50_d;
      ci10_q <= ci10_d;
      ci5_q <= ci5_d;
      ci1_q <= ci1_d;
    end
  end
  assign gnt = gnt_q;
  assign done = done_q;
  assign res_item = r_item_q;
  assign res_coin50 = r50_q;
  assign res_coin10 = r10_q;
  assign res_coin5 = r5_q;
  assign res_coin1 = r1_q;
  assign res_timeout = r_to_q;
  assign acct_err = err_q;
  assign core_itemTypeIn = ci_q;
  assign core_coinInNTD_50 = ci50_q;
  assign core_coinInNTD_10 = ci10_q;
  assign core_coinInNTD_5 = ci5_q;
  assign core_coinInNTD_1 = ci1_q;
endmodule

// File: tb/tb_vending_panel_arbiter.sv
// tb_vending_panel_arbiter: directed vectors against a programmable core model.
module tb_vending_panel_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req = '0;
  logic [7:0] panel_item = '0, pc50 = '0, pc10 = '0, pc5 = '0, pc1 = '0;
  logic [3:0] gnt, done;
  logic [1:0] res_item;
  logic [2:0] res_coin50, res_coin10, res_coin5, res_coin1;
  logic res_timeout, acct_err;
  logic [1:0] ci, ci50, ci10, ci5, ci1;
  logic [1:0] svc = 2'b01, co_item = '0;
  logic [2:0] co50 = '0, co10 = '0, co5 = '0, co1 = '0;
  logic hold = 1'b0;
  int cur_lat = 1, cc = 0, drv = 0, cyc = 0, tests = 0, fails = 0;
  logic [1:0] s_item = '0, s50 = '0, s10 = '0, s5 = '0, s1 = '0;

  always #5 clk = ~clk;

  vending_panel_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req(req), .panel_item(panel_item),
    .panel_coin50(pc50), .panel_coin10(pc10), .panel_coin5(pc5), .panel_coin1(pc1),
    .gnt(gnt), .done(done), .res_item(res_item),
    .res_coin50(res_coin50), .res_coin10(res_coin10), .res_coin5(res_coin5), .res_coin1(res_coin1),
    .res_timeout(res_timeout), .acct_err(acct_err),
    .core_itemTypeIn(ci), .core_coinInNTD_50(ci50), .core_coinInNTD_10(ci10),
    .core_coinInNTD_5(ci5), .core_coinInNTD_1(ci1),
    .core_serviceTypeOut(svc), .core_itemTypeOut(co_item),
    .core_coinOutNTD_50(co50), .core_coinOutNTD_10(co10),
    .core_coinOutNTD_5(co5), .core_coinOutNTD_1(co1)
  );

  // core model: BUSY for cur_lat cycles after sampling a request, one OFF cycle, then ON
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      svc <= 2'b01;
      cc <= 0;
    end else if (svc == 2'b00) svc <= 2'b01;
    else if (svc == 2'b10) begin
      if (!hold) begin
        if (cc <= 0) svc <= 2'b00;
        else cc <= cc - 1;
      end
    end else if (ci != 2'b00) begin
      svc <= 2'b10;
      cc <= cur_lat - 1;
    end
    if ({ci, ci50, ci10, ci5, ci1} != 10'd0) begin
      drv <= drv + 1;
      {s_item, s50, s10, s5, s1} <= {ci, ci50, ci10, ci5, ci1};
    end
  end

  typedef struct {
    int p, item, c50, c10, c5, c1, lat;
    int co_item, co50, co10, co5, co1;
    int e_item, e50, e10, e5, e1, e_to, e_err;
  } vec_t;
  vec_t v[9];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic wait_gnt(output int c);
    c = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (gnt != 4'b0) begin
        c = cyc;
        break;
      end
    end
  endtask

  task automatic wait_done(output int c);
    c = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done != 4'b0) begin
        c = cyc;
        break;
      end
    end
  endtask

  task automatic set_panel(input int p, input int it, input int a, input int b, input int c, input int d);
    panel_item[2*p +: 2] = 2'(it);
    pc50[2*p +: 2] = 2'(a);
    pc10[2*p +: 2] = 2'(b);
    pc5[2*p +: 2] = 2'(c);
    pc1[2*p +: 2] = 2'(d);
  endtask

  task automatic run(input vec_t t);
    int g, d, drv0, exp_lat;
    logic [3:0] m;
    m = 4'b0001 << t.p;
    set_panel(t.p, t.item, t.c50, t.c10, t.c5, t.c1);
    {co_item, co50, co10, co5, co1} = {2'(t.co_item), 3'(t.co50), 3'(t.co10), 3'(t.co5), 3'(t.co1)};
    cur_lat = t.lat;
    hold = t.lat < 0;
    drv0 = drv;
    req = req | m;
    wait_gnt(g);
    chk("gnt", 32'(gnt), 32'(m));
    req = req & ~m;
    set_panel(t.p, 0, 0, 0, 0, 0);
    wait_done(d);
    chk("done", 32'(done), 32'(m));
    exp_lat = t.item == 0 ? 2 : t.lat < 0 ? 18 : t.lat + 3;
    chk("latency", 32'(d - g), 32'(exp_lat));
    chk("result", 32'({res_item, res_coin50, res_coin10, res_coin5, res_coin1, res_timeout}),
        32'({2'(t.e_item), 3'(t.e50), 3'(t.e10), 3'(t.e5), 3'(t.e1), 1'(t.e_to)}));
    @(negedge clk);
    chk("acct_err", 32'(acct_err), 32'(t.e_err));
    chk("done_pulse", 32'(done), 32'd0);
    chk("core_drives", 32'(drv - drv0), t.item != 0 ? 32'd1 : 32'd0);
    if (t.item != 0)
      chk("core_in", 32'({s_item, s50, s10, s5, s1}),
          32'({2'(t.item), 2'(t.c50), 2'(t.c10), 2'(t.c5), 2'(t.c1)}));
    hold = 1'b0;
  endtask

  initial begin
    int g, d, seen;
    // p item c50 c10 c5 c1 lat | core item/c50/c10/c5/c1 | expected item/c50/c10/c5/c1 timeout err
    v[0] = '{0, 1, 0, 1, 0, 0, 3, 1, 0, 0, 0, 2, 1, 0, 0, 0, 2, 0, 0};
    v[1] = '{2, 3, 0, 1, 1, 0, 2, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    v[2] = '{1, 0, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0, 0};
    v[3] = '{3, 2, 0, 2, 0, 0, 1, 2, 0, 0, 1, 0, 2, 0, 0, 1, 0, 0, 0};
    v[4] = '{0, 1, 0, 1, 0, 0, -1, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0};
    v[5] = '{1, 3, 1, 0, 0, 0, 4, 3, 0, 2, 1, 3, 3, 0, 2, 1, 3, 0, 0};
    v[6] = '{2, 0, 3, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0, 3, 3, 3, 3, 0, 0};
    v[7] = '{3, 2, 0, 2, 0, 0, 2, 2, 0, 0, 1, 1, 2, 0, 0, 1, 1, 0, 1};
    v[8] = '{0, 1, 0, 1, 0, 0, 3, 1, 0, 0, 0, 2, 1, 0, 0, 0, 2, 0, 1};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_gnt_done", 32'({gnt, done}), 32'd0);
    chk("rst_result", 32'({res_item, res_coin50, res_coin10, res_coin5, res_coin1, res_timeout}), 32'd0);
    chk("rst_acct_err", 32'(acct_err), 32'd0);
    chk("rst_core_in", 32'({ci, ci50, ci10, ci5, ci1}), 32'd0);
    // two simultaneous requesters starting from pointer 0
    set_panel(1, 0, 0, 0, 0, 1);
    set_panel(3, 0, 0, 0, 1, 0);
    req = 4'b1010;
    wait_gnt(g);
    chk("rr_first", 32'(gnt), 32'b0010);
    req[1] = 1'b0;
    wait_done(d);
    chk("rr_done1", 32'(done), 32'b0010);
    wait_gnt(g);
    chk("rr_second", 32'(gnt), 32'b1000);
    req[3] = 1'b0;
    wait_done(d);
    chk("rr_done3", 32'(done), 32'b1000);
    chk("rr_res3", 32'({res_coin5, res_coin1}), 32'({3'd1, 3'd0}));
    req = 4'b1010;
    wait_gnt(g);
    chk("rr_wrap", 32'(gnt), 32'b0010);
    req = 4'b0000;
    set_panel(1, 0, 0, 0, 0, 0);
    set_panel(3, 0, 0, 0, 0, 0);
    wait_done(d);
    chk("rr_done_wrap", 32'(done), 32'b0010);
    @(negedge clk);
    for (int i = 0; i < 9; i++) run(v[i]);
    // reset while the core is held busy: transaction dropped, sticky error cleared
    set_panel(0, 1, 0, 1, 0, 0);
    hold = 1'b1;
    req = 4'b0001;
    wait_gnt(g);
    chk("mid_gnt", 32'(gnt), 32'b0001);
    req = 4'b0000;
    set_panel(0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_outs", 32'({gnt, done, ci}), 32'd0);
    chk("mid_rst_acct_err", 32'(acct_err), 32'd0);
    chk("mid_rst_result", 32'({res_item, res_coin1}), 32'd0);
    reset = 1'b0;
    hold = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done != 4'b0) seen++;
    end
    chk("no_done_after_rst", 32'(seen), 32'd0);
    run(v[0]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
